// File: rtl/regfile_pkg.sv
// ============================================================================
// regfile_pkg : shared sizing and select-classification types for onehot_regfile
// Revision    : 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

  localparam int DATA_W   = 64;
  localparam int NUM_REGS = 32;
  localparam int ZERO_REG = 31;
  localparam int IDX_W    = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    SEL_ZERO  = 2'd0,
    SEL_VALID = 2'd1,
    SEL_MULTI = 2'd2
  } sel_class_t;

endpackage

`default_nettype wire

// File: rtl/onehot_enc.sv
// ============================================================================
// onehot_enc : one-hot select to index encoder with zero/valid/multi class
// Revision   : 1.0
// ============================================================================
`default_nettype none

import regfile_pkg::*;

module onehot_enc #(
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic [NUM_REGS-1:0] i_sel,
  output logic [IDX_W-1:0]    o_idx,
  output sel_class_t          o_cls
);

  logic [NUM_REGS-1:0] w_sel_m1;

  // Clearing the lowest set bit leaves something behind only when 2+ bits are set.
  assign w_sel_m1 = i_sel - {{(NUM_REGS-1){1'b0}}, 1'b1};

  always_comb begin
    o_idx = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i_sel[i]) o_idx = o_idx | IDX_W'(i);
    end
    if (i_sel == '0)                  o_cls = SEL_ZERO;
    else if ((i_sel & w_sel_m1) != '0) o_cls = SEL_MULTI;
    else                              o_cls = SEL_VALID;
  end

endmodule

`default_nettype wire

// File: rtl/onehot_regfile.sv
// ============================================================================
// onehot_regfile : 32 x 64 register file with one-hot selects, XZR, bypass
// Revision       : 1.0
// ============================================================================
`default_nettype none

import regfile_pkg::*;

module onehot_regfile #(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [NUM_REGS-1:0] wr_sel,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [NUM_REGS-1:0] ra_sel,
  input  logic [NUM_REGS-1:0] rb_sel,
  output logic [DATA_W-1:0]   abus,
  output logic [DATA_W-1:0]   bbus,
  output logic                sel_err,
  output logic                err_sticky
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [IDX_W-1:0] c_zero_idx = IDX_W'(ZERO_REG);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [DATA_W-1:0] r_abus, r_bbus;
  logic              r_sel_err, r_err_sticky;

  logic [IDX_W-1:0]  w_wr_idx, w_ra_idx, w_rb_idx;
  sel_class_t        w_wr_cls, w_ra_cls, w_rb_cls;
  logic              w_wr_ok, w_err;
  logic [DATA_W-1:0] w_a_data, w_b_data;

  onehot_enc #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_enc_wr (
    .i_sel (wr_sel), .o_idx (w_wr_idx), .o_cls (w_wr_cls)
  );
  onehot_enc #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_enc_ra (
    .i_sel (ra_sel), .o_idx (w_ra_idx), .o_cls (w_ra_cls)
  );
  onehot_enc #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_enc_rb (
    .i_sel (rb_sel), .o_idx (w_rb_idx), .o_cls (w_rb_cls)
  );

  assign w_wr_ok = wr_en && (w_wr_cls == SEL_VALID) && (w_wr_idx != c_zero_idx);
  assign w_err   = (wr_en && (w_wr_cls == SEL_MULTI)) ||
                   (w_ra_cls == SEL_MULTI) || (w_rb_cls == SEL_MULTI);

  // A same-edge write to the selected register is forwarded so the read sees the new value.
  always_comb begin
    w_a_data = '0;
    if ((w_ra_cls == SEL_VALID) && (w_ra_idx != c_zero_idx)) begin
      if (w_wr_ok && (w_wr_idx == w_ra_idx)) w_a_data = wr_data;
      else                                   w_a_data = r_regs[w_ra_idx];
    end
  end

  always_comb begin
    w_b_data = '0;
    if ((w_rb_cls == SEL_VALID) && (w_rb_idx != c_zero_idx)) begin
      if (w_wr_ok && (w_wr_idx == w_rb_idx)) w_b_data = wr_data;
      else                                   w_b_data = r_regs[w_rb_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wr_ok) begin
      r_regs[w_wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_abus       <= '0;
      r_bbus       <= '0;
      r_sel_err    <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_abus       <= w_a_data;
      r_bbus       <= w_b_data;
      r_sel_err    <= w_err;
      r_err_sticky <= r_err_sticky | w_err;
    end
  end

  assign abus       = r_abus;
  assign bbus       = r_bbus;
  assign sel_err    = r_sel_err;
  assign err_sticky = r_err_sticky;

endmodule

`default_nettype wire

// File: tb/tb_onehot_regfile.sv
// ============================================================================
// tb_onehot_regfile : randomized + directed bench with behavioural reference
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_onehot_regfile;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [31:0] wr_sel = '0;
  logic [63:0] wr_data = '0;
  logic [31:0] ra_sel = '0;
  logic [31:0] rb_sel = '0;
  logic [63:0] abus, bbus;
  logic        sel_err, err_sticky;

  int n_vec = 0;
  int n_bad = 0;

  logic [63:0] m_regs [32];
  logic [63:0] exp_a = '0, exp_b = '0;
  logic        exp_err = 1'b0, exp_sticky = 1'b0;
  bit          chk_en = 1'b0;

  onehot_regfile dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_data    (wr_data),
    .ra_sel     (ra_sel),
    .rb_sel     (rb_sel),
    .abus       (abus),
    .bbus       (bbus),
    .sel_err    (sel_err),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  function automatic int first_bit(input logic [31:0] s);
    for (int i = 0; i < 32; i++) if (s[i]) return i;
    return -1;
  endfunction

  function automatic logic [63:0] model_read(input logic [31:0] s, input bit wq,
                                             input int wi, input logic [63:0] wd);
    int i;
    if ($countones(s) != 1) return 64'd0;
    i = first_bit(s);
    if (i == 31) return 64'd0;
    if (wq && wi == i) return wd;
    return m_regs[i];
  endfunction

  // Reference model: architectural register array updated from the select rules.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      exp_a = '0; exp_b = '0; exp_err = 1'b0; exp_sticky = 1'b0;
    end else begin
      int  wi;
      bit  wq;
      wi = first_bit(wr_sel);
      wq = wr_en && ($countones(wr_sel) == 1) && (wi != 31);
      exp_a = model_read(ra_sel, wq, wi, wr_data);
      exp_b = model_read(rb_sel, wq, wi, wr_data);
      exp_err = (wr_en && $countones(wr_sel) > 1) || ($countones(ra_sel) > 1) ||
                ($countones(rb_sel) > 1);
      exp_sticky = exp_sticky | exp_err;
      if (wq) m_regs[wi] = wr_data;
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("abus", abus, exp_a);
      check("bbus", bbus, exp_b);
      check("sel_err", {63'd0, sel_err}, {63'd0, exp_err});
      check("err_sticky", {63'd0, err_sticky}, {63'd0, exp_sticky});
    end
  end

  task automatic apply(input logic en, input logic [31:0] ws, input logic [63:0] wd,
                       input logic [31:0] as, input logic [31:0] bs);
    wr_en = en; wr_sel = ws; wr_data = wd; ra_sel = as; rb_sel = bs;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_sel();
    int r;
    int a, b;
    r = $urandom_range(0, 15);
    if (r == 0) return 32'd0;
    if (r == 1) begin
      a = $urandom_range(0, 31);
      b = (a + $urandom_range(1, 31)) % 32;
      return (32'd1 << a) | (32'd1 << b);
    end
    return 32'd1 << $urandom_range(0, 31);
  endfunction

  initial begin
    logic [31:0] ws;
    #3;
    check("rst_abus", abus, 64'd0);
    check("rst_bbus", bbus, 64'd0);
    check("rst_err", {63'd0, sel_err}, 64'd0);
    check("rst_sticky", {63'd0, err_sticky}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;

    apply(1, 32'd1 << 5, 64'h1122334455667788, 0, 0);
    apply(0, 0, 0, 32'd1 << 5, 0);
    check("x5_read", abus, 64'h1122334455667788);
    check("x5_noerr", {63'd0, sel_err}, 64'd0);

    apply(1, 32'd1 << 9, 64'hDEAD, 32'd1 << 9, 32'd1 << 9);
    check("byp_a", abus, 64'hDEAD);
    check("byp_b", bbus, 64'hDEAD);

    apply(1, 32'd1 << 31, 64'hFFFF, 0, 0);
    apply(0, 0, 0, 32'd1 << 31, 32'd1 << 31);
    check("xzr_a", abus, 64'd0);
    check("xzr_b", bbus, 64'd0);
    check("xzr_noerr", {63'd0, sel_err}, 64'd0);

    apply(0, 32'hFF, 64'h5, 0, 0);
    check("wr_dis_noerr", {63'd0, sel_err}, 64'd0);

    apply(1, 32'h6, 64'hAAAA, 0, 0);
    check("multi_err", {63'd0, sel_err}, 64'd1);
    check("multi_sticky", {63'd0, err_sticky}, 64'd1);
    apply(0, 0, 0, 32'd1 << 1, 32'd1 << 2);
    check("x1_unchanged", abus, 64'd0);
    check("x2_unchanged", bbus, 64'd0);
    check("err_pulse_end", {63'd0, sel_err}, 64'd0);
    check("sticky_hold", {63'd0, err_sticky}, 64'd1);

    apply(0, 0, 0, 32'd0, 0);
    check("idle_read", abus, 64'd0);
    check("idle_noerr", {63'd0, sel_err}, 64'd0);
    apply(0, 0, 0, 32'h80000001, 0);
    check("multi_read", abus, 64'd0);
    check("multi_read_err", {63'd0, sel_err}, 64'd1);

    for (int n = 0; n < 400; n++) begin
      ws = rnd_sel();
      apply($urandom_range(0, 3) != 0, ws, {$urandom, $urandom},
            ($urandom_range(0, 4) == 0) ? ws : rnd_sel(),
            ($urandom_range(0, 4) == 0) ? ws : rnd_sel());
    end

    apply(1, 32'd1 << 3, 64'h42, 0, 0);
    apply(0, 0, 0, 32'd1 << 3, 32'd1 << 3);
    check("x3_read", abus, 64'h42);
    wr_en = 1'b1; wr_sel = 32'd1 << 3; wr_data = 64'h99;
    #2 reset = 1'b1;
    #1;
    check("arst_abus", abus, 64'd0);
    check("arst_bbus", bbus, 64'd0);
    check("arst_sticky", {63'd0, err_sticky}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    apply(0, 0, 0, 32'd1 << 3, 32'd1 << 3);
    check("x3_post_rst", abus, 64'd0);
    check("x3_post_rst_b", bbus, 64'd0);

    for (int n = 0; n < 100; n++) begin
      ws = rnd_sel();
      apply($urandom_range(0, 1) != 0, ws, {$urandom, $urandom}, rnd_sel(), ws);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/onehot_regfile.md
Name: onehot_regfile

Overview:
- Register file that consumes one-hot register selects of the kind the instruction decoders produce (bit N set selects register N).
- Holds 32 general registers; X31 is the hard-wired zero register (XZR) per LEGv8.
- Provides two registered read ports (Rn→abus, Rm/Rt→bbus) and one write port (Rd) with same-cycle write-to-read bypass.
- Sits between the decode stage and the ALU/writeback path of the pipelined CPU.

Parameters:
- DATA_W, 64, register and bus data width.
- NUM_REGS, 32, number of architectural registers; the select buses are NUM_REGS bits wide.
- ZERO_REG, 31, index of the hard-wired zero register.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr_en  input  1  write strobe for the Rd port.
- wr_sel  input  NUM_REGS  one-hot destination select.
- wr_data  input  DATA_W  write data.
- ra_sel  input  NUM_REGS  one-hot select for read port A.
- rb_sel  input  NUM_REGS  one-hot select for read port B.
- abus  output  DATA_W  registered read data, port A.
- bbus  output  DATA_W  registered read data, port B.
- sel_err  output  1  registered one-cycle pulse: some select sampled this edge was not exactly one-hot.
- err_sticky  output  1  set by any sel_err and held until reset.

Behaviour:
- Reset (asynchronous, active-high): all registers 0; abus, bbus, sel_err, err_sticky 0. Reset asserted mid-cycle clears state immediately, and a write in flight is lost. The first edge after deassertion operates normally.
- Select classification (per bus, each cycle) uses the onehot_enc result:
  - valid: exactly one bit set; idx is its position.
  - zero: no bits set.
  - multi: two or more bits set.
- Write, at the rising edge:
  - The register at idx is written when wr_en=1, wr_sel is valid and idx≠ZERO_REG.
  - A write to ZERO_REG is silently dropped and is not an error.
  - wr_sel zero with wr_en=1 writes nothing.
  - wr_sel multi with wr_en=1 writes nothing and flags an error.
  - With wr_en=0, wr_sel is ignored and raises no error.
- Read, one-cycle latency: abus/bbus at edge k+1 reflect the ra_sel/rb_sel presented before edge k+1.
  - valid, idx=ZERO_REG: output 0.
  - valid, and a qualifying write to the same idx occurs this edge: output wr_data (bypass; new value wins).
  - valid, otherwise: output the stored register value.
  - zero or multi: output 0. Multi flags an error; zero is a legal idle read with no error.
- Both read ports may select the same register; both receive identical data, including bypass.
- sel_err <= (wr_en & wr_sel multi) | ra multi | rb multi, registered and aligned with abus/bbus. err_sticky <= err_sticky | that same term.
- No stalls and no handshake: a new request is accepted every cycle, with full throughput.

Decomposition:
- Shared package (regfile_pkg): DATA_W, NUM_REGS, ZERO_REG, IDX_W = clog2(NUM_REGS), a sel_class enum {SEL_ZERO, SEL_VALID, SEL_MULTI}.
- Sub-module onehot_enc:
  - Combinational.
  - NUM_REGS-bit input; outputs IDX_W index and sel_class.
  - Instantiated three times (wr, ra, rb).
  - This is the inverse of the decoder producing the selects.

Test Plan:
- Reset, then write 0x1122334455667788 to X5 (wr_sel=1<<5); next cycle ra_sel=1<<5 -> abus=0x1122334455667788 one edge later, sel_err=0.
- Same-edge bypass: wr_sel=1<<9 with data 0xDEAD, and ra_sel=rb_sel=1<<9 in the same cycle -> abus=bbus=0xDEAD after that edge.
- Write 0xFFFF to X31 (wr_sel=1<<31), then read X31 on both ports -> abus=bbus=0, no error.
- Multi-hot: wr_sel=0x00000006 with wr_en=1 -> X1 and X2 unchanged (read back 0); sel_err pulses one cycle; err_sticky stays 1.
- ra_sel=0 -> abus=0, no error. ra_sel=0x80000001 -> abus=0, sel_err=1.
- Assert reset asynchronously between edges after writing X3=0x42 -> abus, bbus and err_sticky clear immediately; a post-reset read of X3 returns 0.
